sprite_motion_writer: RTL and testbench

//  Producer of the 160-bit sprite_data word consumed by the pixel-side sprite hit-test/index logic.

---
 rtl/sprite_motion_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_sprite_motion_writer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion_writer.sv
// Keeps one fighter's position, facing and vertical motion. Once per frame it updates them and
// repacks the 160-bit sprite_data word that the pixel-side hit-test/index logic reads.
module sprite_motion_writer #(
  parameter logic        [15:0] INIT_X    = 16'd320,
  parameter logic        [15:0] GROUND_Y  = 16'd100,
  parameter logic        [15:0] X_MIN     = 16'd0,
  parameter logic        [15:0] X_MAX     = 16'd639,
  parameter logic        [15:0] Y_MAX     = 16'd355,
  parameter logic        [15:0] SPR_W     = 16'd256,
  parameter logic        [15:0] SPR_H     = 16'd125,
  parameter logic        [15:0] RUN_SPEED = 16'd4,
  parameter logic signed [7:0]  JUMP_VEL  = 8'sd12,
  parameter logic signed [7:0]  GRAVITY   = 8'sd1,
  parameter logic signed [7:0]  MAX_FALL  = 8'sd12
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         frame_tick,
  input  logic         move_left,
  input  logic         move_right,
  input  logic         jump,
  input  logic         load_en,
  input  logic [15:0]  load_x,
  input  logic [15:0]  load_y,
  output logic [159:0] sprite_data,
  output logic         data_valid,
  output logic         busy,
  output logic         airborne,
  output logic         overrun
);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} vstate_t;
  typedef enum logic [1:0] {M_HOLD, M_RISE, M_FALL} vmode_t;

  vstate_t            state_q;
  logic        [15:0] x_q;
  logic        [15:0] y_q;
  logic signed [7:0]  vy_q;
  logic               facing_q;
  logic               airborne_q;

  logic               left_q;
  logic               right_q;
  logic               jump_q;
  logic               s1_q;
  logic               s2_q;
  vmode_t             mode_q;
  logic signed [7:0]  vadd_q;
  logic signed [7:0]  vyafter_q;

  logic               busy_q;
  logic               valid_q;
  logic               overrun_q;

  logic               accept;
  logic signed [7:0]  vdec;
  logic signed [7:0]  vfall;
  vmode_t             mode_d;
  logic signed [7:0]  vadd_d;
  logic signed [7:0]  vyafter_d;

  logic        [15:0] ysum;
  logic        [16:0] xinc;
  logic        [15:0] x_d;
  logic        [15:0] y_d;
  logic signed [7:0]  vy_d;
  vstate_t            state_d;
  logic               facing_d;

  logic        [15:0] ld_x;
  logic        [15:0] ld_y;
  logic               ld_fall;

  assign accept = frame_tick && !busy_q;
  assign vdec   = vy_q - GRAVITY;
  assign vfall  = (vdec < -MAX_FALL) ? -MAX_FALL : vdec;

  // First stage: decide which velocity moves Y this frame and what vy becomes afterwards.
  always_comb begin
    mode_d    = M_HOLD;
    vadd_d    = '0;
    vyafter_d = '0;
    case (state_q)
      GROUNDED: begin
        if (jump_q) begin
          mode_d    = M_RISE;
          vadd_d    = JUMP_VEL;
          vyafter_d = JUMP_VEL - GRAVITY;
        end
      end
      RISING: begin
        mode_d    = M_RISE;
        vadd_d    = vy_q;
        vyafter_d = vy_q - GRAVITY;
      end
      FALLING: begin
        mode_d    = M_FALL;
        vadd_d    = vfall;
        vyafter_d = vfall;
      end
      default: begin
        mode_d = M_HOLD;
      end
    endcase
  end

  assign ysum = y_q + {{8{vadd_q[7]}}, vadd_q};
  assign xinc = {1'b0, x_q} + {1'b0, RUN_SPEED};

  // Second stage: apply the motion, clamp to the stage and settle the vertical state.
  always_comb begin
    x_d      = x_q;
    facing_d = facing_q;
    y_d      = y_q;
    vy_d     = vy_q;
    state_d  = state_q;

    if (left_q && !right_q) begin
      facing_d = 1'b0;
      x_d      = (x_q >= X_MIN + RUN_SPEED) ? x_q - RUN_SPEED : X_MIN;
    end else if (right_q && !left_q) begin
      facing_d = 1'b1;
      x_d      = (xinc <= {1'b0, X_MAX}) ? xinc[15:0] : X_MAX;
    end

    case (mode_q)
      M_RISE: begin
        if (ysum > Y_MAX) begin
          y_d     = Y_MAX;
          vy_d    = '0;
          state_d = FALLING;
        end else begin
          y_d     = ysum;
          vy_d    = vyafter_q;
          state_d = (vyafter_q <= 8'sd0) ? FALLING : RISING;
        end
      end
      M_FALL: begin
        // A long fall can wrap Y below zero, so the landing test is signed.
        if ($signed(ysum) <= $signed(GROUND_Y)) begin
          y_d     = GROUND_Y;
          vy_d    = '0;
          state_d = GROUNDED;
        end else begin
          y_d     = ysum;
          vy_d    = vyafter_q;
          state_d = FALLING;
        end
      end
      default: begin
        y_d     = GROUND_Y;
        vy_d    = '0;
        state_d = GROUNDED;
      end
    endcase
  end

  assign ld_x    = (load_x <= X_MIN) ? X_MIN : ((load_x > X_MAX) ? X_MAX : load_x);
  assign ld_y    = (load_y <= GROUND_Y) ? GROUND_Y : ((load_y > Y_MAX) ? Y_MAX : load_y);
  assign ld_fall = (ld_y > GROUND_Y);

  // Respawn wins over everything and discards any half-finished frame update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= GROUNDED;
      x_q        <= INIT_X;
      y_q        <= GROUND_Y;
      vy_q       <= '0;
      facing_q   <= 1'b1;
      airborne_q <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      jump_q     <= 1'b0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      mode_q     <= M_HOLD;
      vadd_q     <= '0;
      vyafter_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else if (load_en) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      busy_q     <= 1'b0;
      x_q        <= ld_x;
      y_q        <= ld_y;
      vy_q       <= '0;
      state_q    <= ld_fall ? FALLING : GROUNDED;
      airborne_q <= ld_fall;
      valid_q    <= 1'b1;
    end else begin
      s1_q    <= accept;
      s2_q    <= s1_q;
      busy_q  <= accept || s1_q || s2_q;
      valid_q <= s2_q;
      if (frame_tick && busy_q) begin
        overrun_q <= 1'b1;
      end
      if (accept) begin
        left_q  <= move_left;
        right_q <= move_right;
        jump_q  <= jump;
      end
      if (s1_q) begin
        mode_q    <= mode_d;
        vadd_q    <= vadd_d;
        vyafter_q <= vyafter_d;
      end
      if (s2_q) begin
        x_q        <= x_d;
        y_q        <= y_d;
        vy_q       <= vy_d;
        facing_q   <= facing_d;
        state_q    <= state_d;
        airborne_q <= (state_d != GROUNDED);
      end
    end
  end

  assign sprite_data = {69'd0, facing_q, 26'd0, x_q, y_q, SPR_W, SPR_H};
  assign data_valid  = valid_q;
  assign busy        = busy_q;
  assign airborne    = airborne_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_motion_writer.sv
// Bench for sprite_motion_writer: a frame-level model of the fighter checked every cycle,
// plus directed scenarios with hand-computed positions.
module tb_sprite_motion_writer;

  logic         clock     = 1'b0;
  logic         resetN    = 1'b0;
  logic         frameTick = 1'b0;
  logic         moveLeft  = 1'b0;
  logic         moveRight = 1'b0;
  logic         jumpIn    = 1'b0;
  logic         loadEn    = 1'b0;
  logic [15:0]  loadX     = 16'd0;
  logic [15:0]  loadY     = 16'd0;
  logic [159:0] spriteData;
  logic         dataValid;
  logic         busy;
  logic         airborne;
  logic         overrun;

  int checks   = 0;
  int failures = 0;

  sprite_motion_writer dut (
    .clock      (clock),
    .reset_n    (resetN),
    .frame_tick (frameTick),
    .move_left  (moveLeft),
    .move_right (moveRight),
    .jump       (jumpIn),
    .load_en    (loadEn),
    .load_x     (loadX),
    .load_y     (loadY),
    .sprite_data(spriteData),
    .data_valid (dataValid),
    .busy       (busy),
    .airborne   (airborne),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Visible fighter as the renderer should see it; phase 0=ground, 1=rising, 2=falling.
  int mX = 320, mY = 100, mVy = 0, mPhase = 0, mFacing = 1;
  bit mValid = 0, mOver = 0;
  int mCyc = 0, busyUntil = -1;
  bit pend = 0;
  int pendDue = 0, pX = 0, pY = 0, pVy = 0, pPhase = 0, pFacing = 0;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One whole frame of the fighter's rules, straight from the game description.
  function automatic void frameStep(input int x, input int y, input int vy, input int ph,
                                    input int fac, input bit l, input bit r, input bit j,
                                    output int nx, output int ny, output int nvy,
                                    output int nph, output int nfac);
    int s;
    nx = x; ny = y; nvy = vy; nph = ph; nfac = fac;
    if (l && !r) begin
      nfac = 0;
      nx = (x >= 4) ? x - 4 : 0;
    end else if (r && !l) begin
      nfac = 1;
      nx = (x + 4 <= 639) ? x + 4 : 639;
    end
    if (ph == 0 && j) begin
      nph = 1;
      nvy = 12;
    end
    if (nph == 1) begin
      s = ny + nvy;
      if (s > 355) begin
        ny = 355; nvy = 0; nph = 2;
      end else begin
        ny = s;
        nvy = nvy - 1;
        if (nvy <= 0) nph = 2;
      end
    end else if (nph == 2) begin
      nvy = nvy - 1;
      if (nvy < -12) nvy = -12;
      s = ny + nvy;
      if (s <= 100) begin
        ny = 100; nvy = 0; nph = 0;
      end else begin
        ny = s;
      end
    end else begin
      ny = 100;
    end
  endfunction

  task automatic resetModel();
    mX = 320; mY = 100; mVy = 0; mPhase = 0; mFacing = 1;
    mValid = 0; mOver = 0; busyUntil = -1; pend = 0;
  endtask

  // Advance the model once per clock: a tick becomes visible three cycles later, a load next cycle.
  initial begin
    bit wasBusy;
    forever begin
      @(posedge clock or negedge resetN);
      if (!resetN) begin
        resetModel();
      end else begin
        mCyc++;
        wasBusy = ((mCyc - 1) <= busyUntil);
        mValid = 0;
        if (loadEn) begin
          pend = 0;
          busyUntil = -1;
          mX = (int'(loadX) > 639) ? 639 : int'(loadX);
          mY = (int'(loadY) < 100) ? 100 : ((int'(loadY) > 355) ? 355 : int'(loadY));
          mVy = 0;
          mPhase = (mY > 100) ? 2 : 0;
          mValid = 1;
        end else begin
          if (pend && pendDue == mCyc) begin
            mX = pX; mY = pY; mVy = pVy; mPhase = pPhase; mFacing = pFacing;
            pend = 0;
            mValid = 1;
          end
          if (frameTick) begin
            if (wasBusy) begin
              mOver = 1;
            end else begin
              frameStep(mX, mY, mVy, mPhase, mFacing, moveLeft, moveRight, jumpIn,
                        pX, pY, pVy, pPhase, pFacing);
              pend = 1;
              pendDue = mCyc + 2;
              busyUntil = mCyc + 2;
            end
          end
        end
      end
    end
  end

  // Compare every output field against the model in the middle of each cycle.
  initial begin
    forever begin
      @(negedge clock);
      checkOutput("x", longint'(spriteData[63:48]), longint'(mX));
      checkOutput("y", longint'(spriteData[47:32]), longint'(mY));
      checkOutput("w", longint'(spriteData[31:16]), 256);
      checkOutput("h", longint'(spriteData[15:0]), 125);
      checkOutput("facing", longint'(spriteData[90]), longint'(mFacing));
      checkOutput("rsvd", longint'(|{spriteData[159:91], spriteData[89:64]}), 0);
      checkOutput("data_valid", longint'(dataValid), longint'(mValid));
      checkOutput("busy", longint'(busy), longint'((mCyc <= busyUntil) ? 1 : 0));
      checkOutput("airborne", longint'(airborne), longint'((mPhase != 0) ? 1 : 0));
      checkOutput("overrun", longint'(overrun), longint'(mOver));
    end
  end

  // One frame tick with the given move levels, then wait (bounded) for its data_valid.
  task automatic applyStimulus(input logic l, input logic r, input logic j);
    bit found;
    int lat;
    found = 0;
    lat = -1;
    @(posedge clock); #2;
    moveLeft = l; moveRight = r; jumpIn = j; frameTick = 1'b1;
    for (int k = 1; k <= 8 && !found; k++) begin
      @(posedge clock); #2;
      frameTick = 1'b0;
      @(negedge clock);
      if (dataValid) begin
        found = 1;
        lat = k;
      end
    end
    checkOutput("dv_latency", longint'(lat), 3);
  endtask

  task automatic applyLoad(input logic [15:0] x, input logic [15:0] y);
    @(posedge clock); #2;
    loadEn = 1'b1; loadX = x; loadY = y;
    @(posedge clock); #2;
    loadEn = 1'b0;
    @(negedge clock);
    checkOutput("load_dv", longint'(dataValid), 1);
  endtask

  task automatic countValid(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (dataValid) cnt++;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: run did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed positions pinning the model.
  initial begin
    int cnt;
    repeat (3) @(posedge clock);
    #2 resetN = 1'b1;
    @(negedge clock);
    checkOutput("rst_x", longint'(spriteData[63:48]), 320);
    checkOutput("rst_y", longint'(spriteData[47:32]), 100);
    checkOutput("rst_w", longint'(spriteData[31:16]), 256);
    checkOutput("rst_h", longint'(spriteData[15:0]), 125);
    checkOutput("rst_facing", longint'(spriteData[90]), 1);
    checkOutput("rst_busy", longint'(busy), 0);

    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("left_x", longint'(spriteData[63:48]), 316);
    checkOutput("left_facing", longint'(spriteData[90]), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("both_x", longint'(spriteData[63:48]), 316);
    checkOutput("both_facing", longint'(spriteData[90]), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("none_x", longint'(spriteData[63:48]), 316);

    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, (i < 10) ? 1'b1 : 1'b0);
      if (i == 0) checkOutput("jump_y1", longint'(spriteData[47:32]), 112);
      if (i == 1) checkOutput("jump_y2", longint'(spriteData[47:32]), 123);
      if (i == 2) checkOutput("jump_y3", longint'(spriteData[47:32]), 133);
      if (i == 11) checkOutput("apex_y", longint'(spriteData[47:32]), 178);
    end
    checkOutput("land_y", longint'(spriteData[47:32]), 100);
    checkOutput("land_airborne", longint'(airborne), 0);

    applyLoad(16'd620, 16'd100);
    for (int i = 0; i < 80; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      if (i == 0) checkOutput("right_x1", longint'(spriteData[63:48]), 624);
    end
    checkOutput("right_max_x", longint'(spriteData[63:48]), 639);
    checkOutput("right_facing", longint'(spriteData[90]), 1);
    checkOutput("no_overrun_yet", longint'(overrun), 0);

    moveLeft = 1'b0; moveRight = 1'b0; jumpIn = 1'b0;
    @(posedge clock); #2 frameTick = 1'b1;
    @(posedge clock); #2 frameTick = 1'b0;
    @(posedge clock); #2 frameTick = 1'b1;
    @(posedge clock); #2 frameTick = 1'b0;
    countValid(6, cnt);
    checkOutput("overrun_flag", longint'(overrun), 1);
    checkOutput("single_dv", longint'(cnt), 1);

    applyLoad(16'd200, 16'd50);
    checkOutput("load_low_x", longint'(spriteData[63:48]), 200);
    checkOutput("load_low_y", longint'(spriteData[47:32]), 100);
    checkOutput("load_low_airborne", longint'(airborne), 0);

    @(posedge clock); #2 moveLeft = 1'b1; frameTick = 1'b1;
    @(posedge clock); #2 frameTick = 1'b0;
    @(posedge clock); #2 loadEn = 1'b1; loadX = 16'd700; loadY = 16'd400;
    @(posedge clock); #2 loadEn = 1'b0;
    @(negedge clock);
    checkOutput("abort_dv", longint'(dataValid), 1);
    checkOutput("abort_x", longint'(spriteData[63:48]), 639);
    checkOutput("abort_y", longint'(spriteData[47:32]), 355);
    checkOutput("abort_airborne", longint'(airborne), 1);
    checkOutput("abort_busy", longint'(busy), 0);
    countValid(5, cnt);
    checkOutput("abort_no_write", longint'(cnt), 0);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 0) checkOutput("fall_y1", longint'(spriteData[47:32]), 354);
    end
    checkOutput("fall_land_y", longint'(spriteData[47:32]), 100);
    checkOutput("fall_land_airborne", longint'(airborne), 0);

    @(posedge clock); #2 moveLeft = 1'b1; frameTick = 1'b1;
    @(posedge clock); #2 frameTick = 1'b0;
    @(posedge clock); #2 resetN = 1'b0;
    repeat (2) @(posedge clock);
    #2 resetN = 1'b1;
    countValid(5, cnt);
    checkOutput("rst_mid_no_dv", longint'(cnt), 0);
    checkOutput("rst_mid_x", longint'(spriteData[63:48]), 320);
    checkOutput("rst_mid_overrun", longint'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
